seed_accum: RTL and testbench

- Parametrised, registered seed accumulator; successor to the original 16-bit combinational seed adder.
- Loads an initial seed, then adds a programmable number of incoming seed terms, one per accepted valid/ready beat.
- Presents the final sum with a valid/ready output handshake and a sticky carry/overflow flag.
- Sits between the seed source and downstream consumers (PRNG or seed-mixing stages).

---
 rtl/seed_accum.sv | 132 +++++++++++++
 tb/tb_seed_accum.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seed_accum.sv
// seed_accum: registered seed accumulator.
// Captures an initial seed on start, then adds num_terms incoming seed terms.
// Each term is accepted on one valid/ready beat. The final sum is presented
// with a valid/ready handshake and a sticky carry/overflow flag.
// Optional build macro SEED_ACCUM_SAT_EN makes the addition saturate instead
// of wrap. With the macro undefined, the addition wraps modulo 2^WIDTH.
module seed_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] init_seed,
  input  logic [CNT_W-1:0] num_terms,
  input  logic [WIDTH-1:0] nseed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] z_add;
  logic             accept;

  // Handshake and status outputs are pure decodes of the state register.
  // This keeps them glitch-free relative to the state and keeps their reset value exact.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;

  // The adder is one bit wider than WIDTH. Bit WIDTH of the sum is the carry out of the MSB.
  assign sum = {1'b0, z} + {1'b0, nseed};

  // Choose the value z takes when a term is accepted: saturated or wrapped.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned; an unassigned path infers a latch.
    z_add = sum[WIDTH-1:0];
`ifdef SEED_ACCUM_SAT_EN
    // Clamp to all-ones on overflow. Once z is all-ones, any nonzero term
    // overflows again, so z stays saturated for the rest of the run.
    if (sum[WIDTH]) begin
      z_add = '1;
    end
`else
    // Wrap modulo 2^WIDTH. The dropped carry bit is kept in the sticky carry flag.
    z_add = sum[WIDTH-1:0];
`endif
  end

  // Next-state logic for the IDLE -> ACCUM -> DONE -> IDLE sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (num_terms == CNT_ZERO) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (cnt == CNT_ONE)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        // start is ignored here, even when it is high in the same cycle as out_ready.
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register. An asynchronous reset drops any run in progress straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: use non-blocking assignments in clocked blocks so every register
    // samples the values from before the edge, whatever order the statements are in.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath registers. Load them on start; update them on each accepted term.
  // In DONE and in IDLE, hold z and carry so the result stays readable until the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z     <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            z     <= init_seed;
            carry <= 1'b0;
            cnt   <= num_terms;
          end
        end
        ACCUM: begin
          if (accept) begin
            z     <= z_add;
            carry <= carry | sum[WIDTH];
            cnt   <= cnt - CNT_ONE;
          end
        end
        default: begin
          // DONE: the result is held until the consumer takes it.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seed_accum.sv
// tb_seed_accum: directed self-checking bench for seed_accum (WIDTH=16, CNT_W=8).
// Inputs change 1 ns after each rising edge, and outputs are sampled at the same point.
// Expected overflow values follow SEED_ACCUM_SAT_EN, so the bench works in both builds.
module tb_seed_accum;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] init_seed;
  logic [7:0]  num_terms;
  logic [15:0] nseed;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic        carry;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int accepts;

  seed_accum #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .init_seed (init_seed),
    .num_terms (num_terms),
    .nseed     (nseed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .carry     (carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock. Count an accept if valid and ready were both high going into the edge.
  task automatic step();
    if (in_valid && in_ready) accepts++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] seed, input logic [7:0] n);
    start     = 1'b1;
    init_seed = seed;
    num_terms = n;
    step();
    start     = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v);
    in_valid = 1'b1;
    nseed    = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic finish_run();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    init_seed = '0;
    num_terms = '0;
    nseed     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    accepts   = 0;

    // ---- Reset held with random inputs ----
    for (int i = 0; i < 4; i++) begin
      start     = 1'($urandom);
      init_seed = 16'($urandom);
      num_terms = 8'($urandom);
      nseed     = 16'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    check("rst_z", 32'(z), 32'h0);
    check("rst_carry", 32'(carry), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; nseed = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("post_rst_z", 32'(z), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_in_ready", 32'(in_ready), 32'h0);

    // ---- Basic run: 0x10 + 1 + 2 + 3 = 0x16, with gaps in in_valid ----
    accepts = 0;
    start_run(16'h0010, 8'd3);
    check("basic_in_ready", 32'(in_ready), 32'h1);
    check("basic_busy", 32'(busy), 32'h1);
    check("basic_z_init", 32'(z), 32'h0010);
    step();                               // gap
    feed(16'h0001);
    check("basic_z_1", 32'(z), 32'h0011);
    nseed = 16'h7777;                     // invalid data on a gap must not be accepted
    step();
    step();
    check("basic_gap_hold", 32'(z), 32'h0011);
    feed(16'h0002);
    step();                               // gap
    feed(16'h0003);
    check("basic_out_valid", 32'(out_valid), 32'h1);
    check("basic_z", 32'(z), 32'h0016);
    check("basic_carry", 32'(carry), 32'h0);
    check("basic_in_ready_done", 32'(in_ready), 32'h0);
    in_valid = 1'b1; nseed = 16'h0100;    // terms must not be accepted in DONE
    step();
    in_valid = 1'b0;
    check("basic_accepts", 32'(accepts), 32'd3);
    check("basic_done_hold", 32'(z), 32'h0016);
    finish_run();
    check("basic_idle_busy", 32'(busy), 32'h0);

    // ---- Overflow: 0xFFF0 + 0x0020 ----
    start_run(16'hFFF0, 8'd1);
    feed(16'h0020);
    check("ovf_out_valid", 32'(out_valid), 32'h1);
`ifdef SEED_ACCUM_SAT_EN
    check("ovf_z", 32'(z), 32'hFFFF);
`else
    check("ovf_z", 32'(z), 32'h0010);
`endif
    check("ovf_carry", 32'(carry), 32'h1);
    finish_run();

    // ---- Sticky carry: 0x8000 + 0x8000 overflows, then + 0x0001 ----
    start_run(16'h8000, 8'd2);
    feed(16'h8000);
    feed(16'h0001);
`ifdef SEED_ACCUM_SAT_EN
    check("sticky_z", 32'(z), 32'hFFFF);
`else
    check("sticky_z", 32'(z), 32'h0001);
`endif
    check("sticky_carry", 32'(carry), 32'h1);
    finish_run();

    // ---- Zero terms: DONE one cycle after start, with no accepts ----
    accepts  = 0;
    in_valid = 1'b1; nseed = 16'h0005;
    start_run(16'h1234, 8'd0);
    check("zero_out_valid", 32'(out_valid), 32'h1);
    check("zero_z", 32'(z), 32'h1234);
    check("zero_in_ready", 32'(in_ready), 32'h0);
    check("zero_carry", 32'(carry), 32'h0);
    in_valid = 1'b0;

    // ---- Backpressure plus start pulses in DONE ----
    for (int i = 0; i < 5; i++) begin
      start     = i[0] ? 1'b0 : 1'b1;
      init_seed = 16'hA000 + 16'(i);
      num_terms = 8'd2;
      step();
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_z", 32'(z), 32'h1234);
    end
    start = 1'b1;                         // start and out_ready together: start is ignored
    init_seed = 16'hBEEF;
    out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    check("bp_idle_busy", 32'(busy), 32'h0);
    check("bp_idle_out_valid", 32'(out_valid), 32'h0);
    step();
    check("bp_idle_stays", 32'(busy), 32'h0);
    check("bp_z_kept", 32'(z), 32'h1234);
    check("zero_accepts", 32'(accepts), 32'd0);

    // ---- Reset mid-run after one of three terms ----
    start_run(16'h0100, 8'd3);
    feed(16'h0001);
    check("mid_z_partial", 32'(z), 32'h0101);
    rst_n = 1'b0;
    #1;
    check("mid_rst_z", 32'(z), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_after_busy", 32'(busy), 32'h0);
    start_run(16'h0005, 8'd2);
    feed(16'h0003);
    step();
    feed(16'h0004);
    check("mid_new_out_valid", 32'(out_valid), 32'h1);
    check("mid_new_z", 32'(z), 32'h000C);
    check("mid_new_carry", 32'(carry), 32'h0);
    finish_run();
    check("mid_new_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
